// File: rtl/invert.sv
// Bit-serial two's-complement negator, LSB first: bits pass until the first 1, later bits invert.
// Optional macro INVERT_REG_OUT_EN registers y (one clock of latency).
module invert #(
   parameter int unsigned WORD_W = 0
) (
   input  logic t_clk,
   input  logic r,
   input  logic i,
   output logic y
);

   localparam int unsigned CNT_W = (WORD_W > 0) ? $clog2(WORD_W + 1) : 1;

   logic seen;
   logic wrap_c;
   logic start_c;
   logic f_c;

   // Optional bit counter re-arms the word once WORD_W bits have been consumed
   generate
      if (WORD_W > 0) begin : g_cnt
         logic [CNT_W-1:0] cnt;

         assign wrap_c = (cnt == CNT_W'(WORD_W));

         always_ff @(posedge t_clk) begin
            if (start_c) begin
               cnt <= CNT_W'(1);
            end else if (!wrap_c) begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end else begin : g_no_cnt
         assign wrap_c = 1'b0;
      end
   endgenerate

   assign start_c = r | wrap_c;
   assign f_c     = seen & ~start_c;

   // seen is reloaded from the LSB at each word start, otherwise sticky
   always_ff @(posedge t_clk) begin
      if (start_c) begin
         seen <= i;
      end else begin
         seen <= seen | i;
      end
   end

`ifdef INVERT_REG_OUT_EN
   always_ff @(posedge t_clk) begin
      y <= i ^ f_c;
   end
`else
   assign y = i ^ f_c;
`endif

endmodule

// File: tb/tb_invert.sv
// Self-checking bench for invert: unbounded-word and WORD_W=4 instances share one stimulus stream.
module tb_invert;

   logic t_clk = 1'b0;
   logic r     = 1'b0;
   logic i     = 1'b0;
   logic y0;
   logic y4;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   // Reference model: accumulated word value and bit index per instance
   logic [63:0] v0 = '0;
   logic [63:0] v4 = '0;
   int          k0 = 0;
   int          k4 = 0;

   always #5 t_clk = ~t_clk;

   invert #(.WORD_W(0)) u_dut0 (.t_clk(t_clk), .r(r), .i(i), .y(y0));
   invert #(.WORD_W(4)) u_dut4 (.t_clk(t_clk), .r(r), .i(i), .y(y4));

   // Output bit k of a word is bit k of the negated k+1-bit prefix value
   task automatic drive_bit(input logic rv, input logic iv, output logic e0, output logic e4);
      logic [63:0] n;
      @(negedge t_clk);
      r = rv;
      i = iv;
      if (rv) begin
         v0 = '0; k0 = 0;
         v4 = '0; k4 = 0;
      end
      if (k4 == 4) begin
         v4 = '0; k4 = 0;
      end
      v0 = v0 | (64'(iv) << k0);
      k0 = k0 + 1;
      n  = -v0;
      e0 = n[k0-1];
      v4 = v4 | (64'(iv) << k4);
      k4 = k4 + 1;
      n  = -v4;
      e4 = n[k4-1];
   endtask

   task automatic settle();
`ifdef INVERT_REG_OUT_EN
      @(posedge t_clk);
      #1;
`else
      #2;
`endif
   endtask

   task automatic test_reset();
      logic e0, e4;
      for (int b = 0; b < 2; b++) begin
         logic iv;
         iv = (b == 1);
         drive_bit(1'b1, iv, e0, e4);
         settle();
         nvec++;
         if (y0 !== iv) begin
            nerr++;
            $display("FAIL reset_y0 bit=%0d got=%b want=%b", b, y0, iv);
         end
         nvec++;
         if (y4 !== iv) begin
            nerr++;
            $display("FAIL reset_y4 bit=%0d got=%b want=%b", b, y4, iv);
         end
      end
   endtask

   task automatic test_neg5();
      logic [3:0] ib = 4'b0101;
      logic [3:0] yb = 4'b1011;
      logic e0, e4;
      for (int b = 0; b < 4; b++) begin
         drive_bit(b == 0, ib[b], e0, e4);
         settle();
         nvec++;
         if (y0 !== yb[b]) begin
            nerr++;
            $display("FAIL neg5_y0 bit=%0d got=%b want=%b", b, y0, yb[b]);
         end
         nvec++;
         if (y4 !== yb[b]) begin
            nerr++;
            $display("FAIL neg5_y4 bit=%0d got=%b want=%b", b, y4, yb[b]);
         end
      end
   endtask

   task automatic test_cb();
      logic [7:0] ib = 8'hCB;
      logic [7:0] yb = 8'h35;
      logic e0, e4;
      for (int b = 0; b < 8; b++) begin
         drive_bit(b == 0, ib[b], e0, e4);
         settle();
         nvec++;
         if (y0 !== yb[b]) begin
            nerr++;
            $display("FAIL cb_y0 bit=%0d got=%b want=%b", b, y0, yb[b]);
         end
         nvec++;
         if (y4 !== e4) begin
            nerr++;
            $display("FAIL cb_y4 bit=%0d got=%b want=%b", b, y4, e4);
         end
      end
   endtask

   task automatic test_leading_zeros();
      logic [3:0] ib = 4'b1100;
      logic [3:0] yb = 4'b0100;
      logic e0, e4;
      for (int b = 0; b < 4; b++) begin
         drive_bit(b == 0, ib[b], e0, e4);
         settle();
         nvec++;
         if (y0 !== yb[b]) begin
            nerr++;
            $display("FAIL lead0_y0 bit=%0d got=%b want=%b", b, y0, yb[b]);
         end
      end
   endtask

   task automatic test_mid_restart();
      logic [3:0] rb = 4'b0101;
      logic [3:0] ib = 4'b1001;
      logic [3:0] yb = 4'b1011;
      logic e0, e4;
      for (int b = 0; b < 4; b++) begin
         drive_bit(rb[b], ib[b], e0, e4);
         settle();
         nvec++;
         if (y0 !== yb[b]) begin
            nerr++;
            $display("FAIL restart_y0 bit=%0d got=%b want=%b", b, y0, yb[b]);
         end
         nvec++;
         if (y4 !== e4) begin
            nerr++;
            $display("FAIL restart_y4 bit=%0d got=%b want=%b", b, y4, e4);
         end
      end
   endtask

   task automatic test_word4_rearm();
      logic [7:0] ib = 8'h61;
      logic [7:0] yb = 8'hAF;
      logic e0, e4;
      for (int b = 0; b < 8; b++) begin
         drive_bit(b == 0, ib[b], e0, e4);
         settle();
         nvec++;
         if (y4 !== yb[b]) begin
            nerr++;
            $display("FAIL rearm_y4 bit=%0d got=%b want=%b", b, y4, yb[b]);
         end
         nvec++;
         if (y0 !== e0) begin
            nerr++;
            $display("FAIL rearm_y0 bit=%0d got=%b want=%b", b, y0, e0);
         end
      end
   endtask

   task automatic test_random();
      logic e0, e4;
      logic rv, iv;
      for (int n = 0; n < 400; n++) begin
         rv = (n == 0) || ($urandom_range(0, 7) == 0) || (k0 >= 56);
         iv = 1'($urandom_range(0, 1));
         drive_bit(rv, iv, e0, e4);
         settle();
         nvec++;
         if (y0 !== e0) begin
            nerr++;
            $display("FAIL rand_y0 n=%0d got=%b want=%b", n, y0, e0);
         end
         nvec++;
         if (y4 !== e4) begin
            nerr++;
            $display("FAIL rand_y4 n=%0d got=%b want=%b", n, y4, e4);
         end
      end
   endtask

   initial begin
      test_reset();
      test_neg5();
      test_cb();
      test_leading_zeros();
      test_mid_restart();
      test_word4_rearm();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/invert.md
Name: invert

Overview:
- Bit-serial two's-complement negator; data arrives LSB first, one bit per clock.
- Output bit = input bit until and including the first 1 of the word; every later bit of the word is inverted.
- Sits in the serial datapath between a shift-out source and a shift-in sink.
- The start of each word is marked by r, or optionally by an internal bit counter.

Parameters:
- WORD_W, default 0. Bits per word for automatic re-arm. 0 = unbounded, so words are delimited by r only. Legal range 0..1024.

Ports:
- t_clk  input  1  clock; all state updates on rising edge.
- r  input  1  synchronous, active-high reset / word-start marker. The bit on i in a cycle with r=1 is the LSB of a new word.
- i  input  1  serial data in, LSB first; sampled on rising t_clk, stable around the edge.
- y  output  1  serial two's complement of i, bit-aligned with i.

Behaviour:
- Internal state:
  - seen (1 bit): a 1 has already been passed in the current word.
  - cnt (clog2(WORD_W+1) bits, present only when WORD_W>0): bits consumed in the current word.
- start = r | (WORD_W>0 && cnt==WORD_W).
- Effective flag f = seen & ~start.
- y = i ^ f (combinational, zero latency).
- Rising-edge update:
  - If start: seen <= i; cnt <= 1.
  - Else: seen <= seen | i; cnt <= cnt+1, saturating at WORD_W.
- Reset is synchronous, active-high, fixed polarity. r does not force y to 0: in the r cycle y = i, because the LSB passes unchanged.
- After r: seen = value of i in the r cycle; cnt = 1.
- Before the first r: seen and y are X. Benches must assert r for at least one edge first.
- r asserted mid-word: the current word is abandoned. The bit in that cycle is the LSB of a new word, and seen is reloaded from it.
- r together with counter wrap: identical result; r takes precedence and both do the same thing.
- All-zero word: y = all zeros (the negation of 0 is 0).
- Most negative value (1 followed by zeros, MSB 1): output equals input, which is correct wrap-around.
- Word length has no effect on arithmetic; no overflow flag.

Optional Feature:
- Macro INVERT_REG_OUT_EN.
- Defined:
  - y comes from a flip-flop: y <= i ^ f on each rising edge, so latency is 1 clock.
  - In the r cycle, y is loaded with i.
  - The output bit stream is otherwise identical, shifted by one cycle.
- Undefined: y is combinational with zero latency, as in Behaviour.

Test Plan:
- 4-bit word 5: r=1 with i=1, then i=0,1,0 with r=0 -> y=1,1,0,1 (value 11, i.e. -5 mod 16).
- 8-bit word 0xCB: r=1 with i=1, then i=1,0,1,0,0,1,1 -> y=1,0,1,0,1,1,0,0 (0x35).
- Leading zeros: r=1 with i=0, then i=0,1,1 -> y=0,0,1,0. Zeros pass unchanged until the first 1.
- Mid-word restart: after 0x?1 has set seen, assert r with i=0, then i=1 -> y=0,1. seen is cleared by r.
- WORD_W=4, r pulsed once: stream 1,0,0,0, 0,1,1,0 -> y=1,1,1,1, 0,1,0,1. The counter re-arms automatically.
- With INVERT_REG_OUT_EN: repeat the 5 case -> y=1,1,0,1, each bit appearing one clock later than its input bit.
